// File: rtl/perceptron_pkg.sv
// Shared types and sizing helpers for the weighted perceptron datapath.
package perceptron_pkg;

  typedef enum logic [1:0] {
    ACT_IDENT     = 2'b00,
    ACT_RELU      = 2'b01,
    ACT_STEP      = 2'b10,
    ACT_IDENT_ALT = 2'b11
  } act_mode_t;

  // Full-precision width of a dot product of n lanes of dw x ww signed terms.
  function automatic int result_width(input int dw, input int ww, input int n);
    return dw + ww + $clog2(n);
  endfunction

endpackage

// File: rtl/adder_tree_en.sv
// Stall-capable pipelined binary adder tree: one register level per tree level,
// a valid chain and a side-band chain that travel alongside the partial sums.
module adder_tree_en #(
  parameter int N      = 8,
  parameter int IN_W   = 24,
  parameter int OUT_W  = 27,
  parameter int SIDE_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [N-1:0][IN_W-1:0] in_data,
  input  logic [SIDE_W-1:0]     in_side,
  output logic                  out_valid,
  output logic [OUT_W-1:0]      out_data,
  output logic [SIDE_W-1:0]     out_side
);

  localparam int LEVELS = $clog2(N);
  localparam int P      = 1 << LEVELS;

  // Heap layout: node k sums children 2k and 2k+1; leaves live at P..2P-1.
  logic [OUT_W-1:0]             node_q [1:P-1];
  logic [OUT_W-1:0]             heap   [1:2*P-1];
  logic [LEVELS:1]              vld_pipe_q;
  logic [LEVELS:1][SIDE_W-1:0]  side_q;

  always_comb begin
    heap = '{default: '0};
    for (int k = 1; k < P; k++) heap[k] = node_q[k];
    for (int j = 0; j < N; j++)
      heap[P+j] = {{(OUT_W-IN_W){in_data[j][IN_W-1]}}, in_data[j]};
    // Leaves beyond N stay at zero from the default above.
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k < P; k++) node_q[k] <= '0;
      vld_pipe_q <= '0;
      side_q     <= '0;
    end else if (en) begin
      for (int k = 1; k < P; k++) node_q[k] <= heap[2*k] + heap[2*k+1];
      vld_pipe_q[1] <= in_valid;
      side_q[1]     <= in_side;
      for (int l = 2; l <= LEVELS; l++) begin
        vld_pipe_q[l] <= vld_pipe_q[l-1];
        side_q[l]     <= side_q[l-1];
      end
    end
  end

  assign out_valid = vld_pipe_q[LEVELS];
  assign out_data  = node_q[1];
  assign out_side  = side_q[LEVELS];

endmodule

// File: rtl/weighted_perceptron.sv
// Weighted-sum perceptron: weight file, multiply stage, pipelined adder tree and
// activation stage, all advancing together under a single downstream backpressure.
module weighted_perceptron
  import perceptron_pkg::*;
#(
  parameter int N            = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int RESULT_WIDTH = result_width(DATA_WIDTH, WEIGHT_WIDTH, N)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N-1:0][DATA_WIDTH-1:0]   data_in,
  input  logic                           w_we,
  input  logic [$clog2(N)-1:0]           w_addr,
  input  logic signed [WEIGHT_WIDTH-1:0] w_data,
  input  logic [1:0]                     act_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [RESULT_WIDTH-1:0] data_out
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

  logic [N-1:0][WEIGHT_WIDTH-1:0] w_q;
  logic [N-1:0][PW-1:0]           prod_d, prod_q;
  logic                           mul_vld_q;
  act_mode_t                      mul_mode_q;
  logic                           tree_vld;
  logic [RESULT_WIDTH-1:0]        tree_sum;
  logic [1:0]                     tree_side;
  logic signed [RESULT_WIDTH-1:0] sum, act_d;
  logic                           out_valid_q;
  logic signed [RESULT_WIDTH-1:0] data_out_q;
  logic                           adv;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Weights update independently of the pipeline; an accept in the same cycle
  // multiplies against the pre-write value because both sample the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) w_q[i] <= WEIGHT_WIDTH'(1);
    end else if (w_we && (32'(w_addr) < N)) begin
      w_q[w_addr] <= w_data;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      prod_d[i] = PW'($signed(data_in[i])) * PW'($signed(w_q[i]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_vld_q  <= 1'b0;
      prod_q     <= '0;
      mul_mode_q <= ACT_IDENT;
    end else if (adv) begin
      mul_vld_q  <= in_valid;
      prod_q     <= prod_d;
      mul_mode_q <= act_mode_t'(act_mode);
    end
  end

  adder_tree_en #(
    .N      (N),
    .IN_W   (PW),
    .OUT_W  (RESULT_WIDTH),
    .SIDE_W (2)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (adv),
    .in_valid  (mul_vld_q),
    .in_data   (prod_q),
    .in_side   (mul_mode_q),
    .out_valid (tree_vld),
    .out_data  (tree_sum),
    .out_side  (tree_side)
  );

  assign sum = $signed(tree_sum);

  always_comb begin
    act_d = sum;
    case (act_mode_t'(tree_side))
      ACT_RELU: if (sum < 0) act_d = '0;
      ACT_STEP: act_d = (sum > 0) ? RESULT_WIDTH'(1) : '0;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else if (adv) begin
      out_valid_q <= tree_vld;
      data_out_q  <= act_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: doc/weighted_perceptron.md
WEIGHTED_PERCEPTRON -- requirements
Module: weighted_perceptron

Interface
REQ-001 Parameter N, default 8, input count including bias lane N-1; SHALL be >= 2.
REQ-002 Parameter DATA_WIDTH, default 16, signed input sample width.
REQ-003 Parameter WEIGHT_WIDTH, default 8, signed weight width.
REQ-004 Parameter RESULT_WIDTH, default DATA_WIDTH+WEIGHT_WIDTH+$clog2(N), signed output width.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 in_valid  input  1  sample vector valid.
REQ-008 in_ready  output  1  block accepts a vector this cycle.
REQ-009 data_in  input  N x DATA_WIDTH signed  sample vector; lane N-1 is bias.
REQ-010 w_we  input  1  weight write strobe.
REQ-011 w_addr  input  $clog2(N)  weight index.
REQ-012 w_data  input  WEIGHT_WIDTH signed  weight value.
REQ-013 act_mode  input  2  activation: 00 identity, 01 ReLU, 10 step, 11 identity.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 data_out  output  RESULT_WIDTH signed  activated weighted sum.

Function
REQ-017 Result SHALL be act(sum over i of data_in[i]*w[i]), full-precision signed, no truncation or saturation.
REQ-018 Pipeline: 1 multiply stage, $clog2(N) adder-tree stages, 1 activation stage; latency L = $clog2(N)+2 cycles (N=8: 5) from accepted input to out_valid, absent stalls.
REQ-019 Advance enable adv = !out_valid || out_ready; in_ready SHALL equal adv; all stages and the valid shift chain SHALL hold when adv=0.
REQ-020 A vector SHALL be accepted only when in_valid && in_ready; bubbles propagate as invalid stages.
REQ-021 Throughput SHALL be one vector per cycle with out_ready held high.
REQ-022 data_out and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-023 Weight write SHALL occur when w_we=1 regardless of adv; w_addr >= N SHALL be ignored.
REQ-024 A weight written in cycle t SHALL apply to vectors accepted in cycle t+1 or later; vectors already in the pipeline SHALL be unaffected.
REQ-025 Simultaneous w_we and accept in the same cycle SHALL use the old weight for that vector.
REQ-026 act_mode SHALL be sampled with the vector at accept and carried down the pipeline.
REQ-027 ReLU: negative sum -> 0; step: sum > 0 -> 1 else 0.
REQ-028 Odd or non-power-of-2 N: missing tree leaves SHALL be zero-padded.

Reset
REQ-029 On rst_n=0 at a clock edge: out_valid=0, data_out=0, all stage valids=0, all weights=+1.
REQ-030 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-031 Reset mid-operation SHALL discard all in-flight vectors; no out_valid pulse SHALL result from them.

Structure
REQ-032 Package perceptron_pkg SHALL hold act_mode_t enum, ACT_* constants, and result-width helper function.
REQ-033 Sub-module adder_tree_en SHALL implement the stall-capable pipelined tree (enable, valid chain, zero padding).
REQ-034 Weight register file and multiply/activation stages SHALL live in weighted_perceptron.

Verification (N=8, DATA_WIDTH=16, WEIGHT_WIDTH=8)
REQ-035 Post-reset, data_in all 3, act_mode=00 -> data_out=24 exactly 5 cycles after accept.
REQ-036 Write w[0..6]=3, w[7]=1, data_in=[1..7, bias 5] -> 3*28+5=89; act_mode=01 with data_in all -2 -> 0; act_mode=10 -> 1 for 89, 0 for 0.
REQ-037 Extremes: all data_in=-32768, all weights=-128 -> 33554432; all data_in=32767, weights=-128 -> -33553408 (identity).
REQ-038 Back-to-back 20 vectors, out_ready toggled randomly -> all 20 results in order, no loss or duplication, data_out stable while stalled.
REQ-039 w_we to w[0]=5 in same cycle as accept of data_in[0]=1 (others 0) -> result 1; next vector -> 5.
REQ-040 Assert rst_n=0 with 3 vectors in flight -> no out_valid afterward; next vector returns with weights=+1.
